// File: rtl/led_pwm_fader.sv
// Eight-channel LED fader: each channel ramps its PWM level by one step per
// prescaler tick toward a target chosen from led_in/brightness.
module led_pwm_fader #(
  parameter int unsigned STEP_CYCLES = 23437,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [7:0]          led_out,
  output logic                busy
);

  localparam int unsigned NCH     = 8;
  localparam int unsigned PRESC_W = 24;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_CYCLES - 32'd1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(32'd1);
  localparam logic [PRESC_W-1:0]  PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO   = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(32'd1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } fade_state_e;

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PRESC_W-1:0]  presc_r;
  logic                tick_s;

  logic [PWM_BITS-1:0] target_s    [NCH];
  logic [PWM_BITS-1:0] level_r     [NCH];
  logic [PWM_BITS-1:0] level_nxt_s [NCH];
  fade_state_e         state_r     [NCH];
  fade_state_e         state_nxt_s [NCH];

  logic [7:0] led_out_r;
  logic [7:0] led_nxt_s;
  logic       busy_r;
  logic       busy_nxt_s;

  assign tick_s = (presc_r == PRESC_LAST);

  // Free-running PWM counter and fade-step prescaler
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt_r <= LVL_ZERO;
      presc_r   <= PRESC_ZERO;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
      presc_r   <= tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
    end
  end

  // Per-channel target, one-step level move and fade-state classification
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      target_s[i]    = led_in[i] ? brightness : LVL_ZERO;
      level_nxt_s[i] = level_r[i];
      state_nxt_s[i] = ST_OFF;

      if (tick_s && (level_r[i] < target_s[i])) begin
        level_nxt_s[i] = level_r[i] + LVL_ONE;
      end else if (tick_s && (level_r[i] > target_s[i])) begin
        level_nxt_s[i] = level_r[i] - LVL_ONE;
      end else begin
        level_nxt_s[i] = level_r[i];
      end

      // State reflects the post-update level so it agrees with level_r next cycle
      if (level_nxt_s[i] < target_s[i]) begin
        state_nxt_s[i] = ST_RISING;
      end else if (level_nxt_s[i] > target_s[i]) begin
        state_nxt_s[i] = ST_FALLING;
      end else if (target_s[i] == LVL_ZERO) begin
        state_nxt_s[i] = ST_OFF;
      end else begin
        state_nxt_s[i] = ST_ON;
      end
    end
  end

  // Fade level and state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        level_r[i] <= LVL_ZERO;
        state_r[i] <= ST_OFF;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        level_r[i] <= level_nxt_s[i];
        state_r[i] <= state_nxt_s[i];
      end
    end
  end

  // PWM compare and busy reduction; OFF forces the drive low as a second guard
  always_comb begin
    led_nxt_s  = 8'h00;
    busy_nxt_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      case (state_r[i])
        ST_OFF:  led_nxt_s[i] = 1'b0;
        default: led_nxt_s[i] = (pwm_cnt_r < level_r[i]);
      endcase
      if (level_r[i] != target_s[i]) begin
        busy_nxt_s = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      led_out_r <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      led_out_r <= led_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign led_out = led_out_r;
  assign busy    = busy_r;

endmodule
